// File: rtl/ram_pkg.sv
// ram_pkg: shared types and sizes for the SDRAM bank arbiter.
// Exports bank_state_t plus the bank count and the bank/row widths.
package ram_pkg;

    localparam int NBANKS = 4;
    localparam int ROW_W  = 12;
    localparam int BANK_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        COOL = 2'd2
    } bank_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from i_ptr upward.
// Ports: i_elig (candidates), i_ptr (start index), o_gnt (one-hot), o_valid.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_elig,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic                 o_valid
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = (int'(i_ptr) + i) % N;
            if (!w_found && i_elig[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: grants SDRAM banks to requesters for fixed bursts, routes
// beats to owners and closes rows; one controller command per two cycles.
// Ports: req/req_write/req_bank/req_row in, gnt/beat/done/err out,
// read_rq/write_rq/stop_access/access_bank/address_select to the
// controller, op_trigger/op_bank beat events back from it.
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 8,
    parameter int TRP       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_write,
    input  logic [BANK_W*NREQ-1:0]  req_bank,
    input  logic [ROW_W*NREQ-1:0]   req_row,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         beat,
    output logic [NREQ-1:0]         done,
    output logic                    err,
    output logic                    read_rq,
    output logic                    write_rq,
    output logic                    stop_access,
    output logic [BANK_W-1:0]       access_bank,
    output logic [ROW_W-1:0]        address_select,
    input  logic                    op_trigger,
    input  logic [BANK_W-1:0]       op_bank
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam int TW = 4;

    bank_state_t     r_state     [NBANKS];
    bank_state_t     w_state_nxt [NBANKS];
    logic [OW-1:0]   r_owner     [NBANKS];
    logic [OW-1:0]   w_owner_nxt [NBANKS];
    logic [CW-1:0]   r_cnt       [NBANKS];
    logic [CW-1:0]   w_cnt_nxt   [NBANKS];
    logic [TW-1:0]   r_cool      [NBANKS];
    logic [TW-1:0]   w_cool_nxt  [NBANKS];
    logic [OW-1:0]   r_ptr;
    logic [OW-1:0]   w_ptr_nxt;

    logic [NREQ-1:0]   w_open_elig;
    logic [NBANKS-1:0] w_close_elig;
    logic [NREQ-1:0]   w_rr_gnt;
    logic              w_rr_valid;
    logic [OW-1:0]     w_win;
    logic [BANK_W-1:0] w_open_bank;
    logic [BANK_W-1:0] w_close_bank;
    logic              w_close_any;
    logic              w_slot_free;
    logic              w_do_open;
    logic              w_do_close;
    logic              w_beat_hit;

    logic [NREQ-1:0]   w_gnt_nxt;
    logic [NREQ-1:0]   w_beat_nxt;
    logic [NREQ-1:0]   w_done_nxt;
    logic              w_err_nxt;
    logic              w_rd_nxt;
    logic              w_wr_nxt;
    logic              w_stop_nxt;
    logic [BANK_W-1:0] w_bank_nxt;
    logic [ROW_W-1:0]  w_addr_nxt;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            w_open_elig[k] = req[k] && !gnt[k] &&
                (r_state[req_bank[k*BANK_W +: BANK_W]] == IDLE);
        end
        for (int b = 0; b < NBANKS; b++) begin
            w_close_elig[b] = (r_state[b] == OPEN) &&
                ((r_cnt[b] == CW'(BURST_LEN)) || !req[r_owner[b]]);
        end
    end

    rr_arbiter #(.N(NREQ)) u_rr (
        .i_elig  (w_open_elig),
        .i_ptr   (r_ptr),
        .o_gnt   (w_rr_gnt),
        .o_valid (w_rr_valid)
    );

    always_comb begin
        w_win = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_rr_gnt[k]) w_win = OW'(k);
        end
    end

    // descending scan so the lowest close-eligible bank wins
    always_comb begin
        w_close_any  = 1'b0;
        w_close_bank = '0;
        for (int b = NBANKS - 1; b >= 0; b--) begin
            if (w_close_elig[b]) begin
                w_close_any  = 1'b1;
                w_close_bank = BANK_W'(b);
            end
        end
    end

    // the controller is edge-triggered: a pulse last cycle blocks this one
    assign w_slot_free = !(read_rq || write_rq || stop_access);
    assign w_do_close  = w_slot_free && w_close_any;
    assign w_do_open   = w_slot_free && !w_close_any && w_rr_valid;
    assign w_open_bank = req_bank[w_win*BANK_W +: BANK_W];
    assign w_beat_hit  = op_trigger && (r_state[op_bank] == OPEN);
    assign w_ptr_nxt   = (int'(w_win) == NREQ - 1) ? '0 : w_win + OW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBANKS; b++) begin
                r_state[b] <= IDLE;
                r_owner[b] <= '0;
                r_cnt[b]   <= '0;
                r_cool[b]  <= '0;
            end
            r_ptr <= '0;
        end else begin
            for (int b = 0; b < NBANKS; b++) begin
                r_state[b] <= w_state_nxt[b];
                r_owner[b] <= w_owner_nxt[b];
                r_cnt[b]   <= w_cnt_nxt[b];
                r_cool[b]  <= w_cool_nxt[b];
            end
            if (w_do_open) r_ptr <= w_ptr_nxt;
        end
    end

    always_comb begin
        for (int b = 0; b < NBANKS; b++) begin
            w_state_nxt[b] = r_state[b];
            w_owner_nxt[b] = r_owner[b];
            w_cnt_nxt[b]   = r_cnt[b];
            w_cool_nxt[b]  = r_cool[b];
            if (r_state[b] == COOL) begin
                if (r_cool[b] <= TW'(1)) w_state_nxt[b] = IDLE;
                else w_cool_nxt[b] = r_cool[b] - TW'(1);
            end
        end
        if (w_beat_hit && (r_cnt[op_bank] != CW'(BURST_LEN))) begin
            w_cnt_nxt[op_bank] = r_cnt[op_bank] + CW'(1);
        end
        if (w_do_close) begin
            w_state_nxt[w_close_bank] = COOL;
            w_cool_nxt[w_close_bank]  = TW'(TRP);
        end
        if (w_do_open) begin
            w_state_nxt[w_open_bank] = OPEN;
            w_owner_nxt[w_open_bank] = w_win;
            w_cnt_nxt[w_open_bank]   = '0;
        end
    end

    always_comb begin
        w_gnt_nxt  = gnt;
        w_beat_nxt = '0;
        w_done_nxt = '0;
        w_err_nxt  = err || (op_trigger && !w_beat_hit);
        w_rd_nxt   = 1'b0;
        w_wr_nxt   = 1'b0;
        w_stop_nxt = w_do_close;
        w_bank_nxt = '0;
        w_addr_nxt = '0;
        if (w_beat_hit) w_beat_nxt[r_owner[op_bank]] = 1'b1;
        if (w_do_close) begin
            w_bank_nxt                      = w_close_bank;
            w_gnt_nxt[r_owner[w_close_bank]]  = 1'b0;
            w_done_nxt[r_owner[w_close_bank]] = 1'b1;
        end
        if (w_do_open) begin
            w_bank_nxt       = w_open_bank;
            w_addr_nxt       = req_row[w_win*ROW_W +: ROW_W];
            w_gnt_nxt[w_win] = 1'b1;
            w_rd_nxt         = !req_write[w_win];
            w_wr_nxt         = req_write[w_win];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt            <= '0;
            beat           <= '0;
            done           <= '0;
            err            <= 1'b0;
            read_rq        <= 1'b0;
            write_rq       <= 1'b0;
            stop_access    <= 1'b0;
            access_bank    <= '0;
            address_select <= '0;
        end else begin
            gnt            <= w_gnt_nxt;
            beat           <= w_beat_nxt;
            done           <= w_done_nxt;
            err            <= w_err_nxt;
            read_rq        <= w_rd_nxt;
            write_rq       <= w_wr_nxt;
            stop_access    <= w_stop_nxt;
            access_bank    <= w_bank_nxt;
            address_select <= w_addr_nxt;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scenario tasks plus randomized bursts against a
// transaction-level model of ownership, rotation order and beat counts.
module tb_ram_arbiter;

    localparam int NREQ = 4;
    localparam int BL   = 8;
    localparam int TRP  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_write = '0;
    logic [2*NREQ-1:0] req_bank = '0;
    logic [12*NREQ-1:0] req_row = '0;
    logic [NREQ-1:0]   gnt, beat, done;
    logic              err, read_rq, write_rq, stop_access;
    logic [1:0]        access_bank;
    logic [11:0]       address_select;
    logic              op_trigger = 1'b0;
    logic [1:0]        op_bank = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mp = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.NREQ(NREQ), .BURST_LEN(BL), .TRP(TRP)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_write(req_write),
        .req_bank(req_bank), .req_row(req_row), .gnt(gnt), .beat(beat),
        .done(done), .err(err), .read_rq(read_rq), .write_rq(write_rq),
        .stop_access(stop_access), .access_bank(access_bank),
        .address_select(address_select), .op_trigger(op_trigger),
        .op_bank(op_bank)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [NREQ-1:0] oh(input int k);
        return NREQ'(1) << k;
    endfunction

    function automatic logic [33:0] outs();
        return {gnt, beat, done, err, read_rq, write_rq, stop_access,
                access_bank, address_select};
    endfunction

    task automatic set_req(input int k, input logic w,
                           input logic [1:0] b, input logic [11:0] r);
        req_write[k]      = w;
        req_bank[2*k +: 2] = b;
        req_row[12*k +: 12] = r;
        req[k]            = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (outs() !== 34'd0) begin
            errors++;
            $display("FAIL reset_outs got %h want 0", outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (outs() !== 34'd0) begin
            errors++;
            $display("FAIL idle_after_reset got %h want 0", outs());
        end
        mp = 0;
    endtask

    task automatic test_single_read();
        bit got;
        set_req(0, 1'b0, 2'd2, 12'h0A5);
        tick();
        checks++;
        if (read_rq !== 1'b1 || write_rq !== 1'b0 || access_bank !== 2'd2 ||
            address_select !== 12'h0A5) begin
            errors++;
            $display("FAIL single_open rd=%b wr=%b bank=%0d row=%h want 1 0 2 0a5",
                     read_rq, write_rq, access_bank, address_select);
        end
        checks++;
        if (gnt !== oh(0)) begin
            errors++;
            $display("FAIL single_gnt got %b want %b", gnt, oh(0));
        end
        mp = 1;
        tick();
        checks++;
        if ({read_rq, write_rq, stop_access} !== 3'b000) begin
            errors++;
            $display("FAIL single_pulse_width got %b want 000",
                     {read_rq, write_rq, stop_access});
        end
        for (int i = 0; i < BL; i++) begin
            op_trigger = 1'b1;
            op_bank    = 2'd2;
            tick();
            checks++;
            if (beat !== oh(0)) begin
                errors++;
                $display("FAIL single_beat%0d got %b want %b", i, beat, oh(0));
            end
        end
        op_trigger = 1'b0;
        got = 0;
        for (int t = 0; t < 4 && !got; t++) begin
            tick();
            if (stop_access === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL single_close got none want stop_access");
        end else if (access_bank !== 2'd2 || done !== oh(0) || gnt !== '0) begin
            errors++;
            $display("FAIL single_close bank=%0d done=%b gnt=%b want 2 0001 0000",
                     access_bank, done, gnt);
        end
        req[0] = 1'b0;
        tick();
        checks++;
        if (done !== '0 || stop_access !== 1'b0) begin
            errors++;
            $display("FAIL single_done_width done=%b stop=%b want 0 0",
                     done, stop_access);
        end
        settle(TRP + 2);
    endtask

    task automatic test_round_robin();
        logic [11:0] rows [NREQ];
        logic        wr   [NREQ];
        int          order [$];
        int          seen, last;
        for (int k = 0; k < NREQ; k++) begin
            rows[k] = 12'($urandom);
            wr[k]   = 1'($urandom);
            set_req(k, wr[k], 2'(k), rows[k]);
            order.push_back((mp + k) % NREQ);
        end
        seen = 0;
        last = -1;
        for (int t = 0; t < 3 * NREQ + 4 && seen < NREQ; t++) begin
            tick();
            if (read_rq || write_rq || stop_access) begin
                int e;
                e = order[seen];
                checks++;
                if (stop_access !== 1'b0 || read_rq !== !wr[e] ||
                    write_rq !== wr[e] || access_bank !== 2'(e) ||
                    address_select !== rows[e]) begin
                    errors++;
                    $display("FAIL rr_open%0d rd=%b wr=%b bank=%0d row=%h want req %0d row %h",
                             seen, read_rq, write_rq, access_bank,
                             address_select, e, rows[e]);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 2) begin
                        errors++;
                        $display("FAIL rr_spacing got %0d want 2", cyc - last);
                    end
                end
                last = cyc;
                seen++;
            end
        end
        checks++;
        if (seen !== NREQ || gnt !== {NREQ{1'b1}}) begin
            errors++;
            $display("FAIL rr_all opens=%0d gnt=%b want %0d 1111", seen, gnt, NREQ);
        end
        req = '0;
        seen = 0;
        for (int t = 0; t < 3 * NREQ + 4 && seen < NREQ; t++) begin
            tick();
            if (stop_access) begin
                checks++;
                if (access_bank !== 2'(seen) || done !== oh(seen)) begin
                    errors++;
                    $display("FAIL rr_close%0d bank=%0d done=%b want %0d %b",
                             seen, access_bank, done, seen, oh(seen));
                end
                seen++;
            end
        end
        checks++;
        if (seen !== NREQ || gnt !== '0) begin
            errors++;
            $display("FAIL rr_closed closes=%0d gnt=%b want %0d 0000", seen, gnt, NREQ);
        end
        settle(TRP + 2);
    endtask

    task automatic test_bank_conflict();
        logic [11:0] rows [NREQ];
        int w, o, tc;
        bit got;
        rows[1] = 12'($urandom);
        rows[2] = 12'($urandom);
        set_req(1, 1'b0, 2'd1, rows[1]);
        set_req(2, 1'b1, 2'd1, rows[2]);
        w = (((1 - mp + NREQ) % NREQ) < ((2 - mp + NREQ) % NREQ)) ? 1 : 2;
        o = 3 - w;
        tick();
        checks++;
        if ((read_rq || write_rq) !== 1'b1 || access_bank !== 2'd1 ||
            address_select !== rows[w] || gnt !== oh(w)) begin
            errors++;
            $display("FAIL conflict_first bank=%0d row=%h gnt=%b want 1 %h %b",
                     access_bank, address_select, gnt, rows[w], oh(w));
        end
        mp = (w + 1) % NREQ;
        tick();
        for (int i = 0; i < BL; i++) begin
            op_trigger = 1'b1;
            op_bank    = 2'd1;
            tick();
            checks++;
            if (beat !== oh(w)) begin
                errors++;
                $display("FAIL conflict_beat%0d got %b want %b", i, beat, oh(w));
            end
        end
        op_trigger = 1'b0;
        got = 0;
        for (int t = 0; t < 4 && !got; t++) begin
            tick();
            if (stop_access) got = 1;
        end
        checks++;
        if (!got || done !== oh(w)) begin
            errors++;
            $display("FAIL conflict_close stop=%b done=%b want 1 %b", got, done, oh(w));
        end
        tc = cyc;
        req[w] = 1'b0;
        got = 0;
        for (int t = 0; t < TRP + 8 && !got; t++) begin
            tick();
            if (read_rq || write_rq) got = 1;
        end
        checks++;
        if (!got || cyc - tc < TRP + 1 || cyc - tc > TRP + 2 ||
            address_select !== rows[o] || gnt !== oh(o) ||
            write_rq !== (o == 2)) begin
            errors++;
            $display("FAIL conflict_second gap=%0d row=%h gnt=%b want gap>=%0d row %h gnt %b",
                     cyc - tc, address_select, gnt, TRP + 1, rows[o], oh(o));
        end
        mp = (o + 1) % NREQ;
        req[o] = 1'b0;
        got = 0;
        for (int t = 0; t < 4 && !got; t++) begin
            tick();
            if (stop_access) got = 1;
        end
        checks++;
        if (!got || done !== oh(o)) begin
            errors++;
            $display("FAIL conflict_release stop=%b done=%b want 1 %b", got, done, oh(o));
        end
        settle(TRP + 2);
    endtask

    task automatic test_early_release();
        logic [1:0]  b;
        logic [11:0] r;
        int lat;
        bit stray;
        b = 2'($urandom_range(0, 3));
        r = 12'($urandom);
        set_req(3, 1'b1, b, r);
        tick();
        checks++;
        if (write_rq !== 1'b1 || access_bank !== b || address_select !== r ||
            gnt !== oh(3)) begin
            errors++;
            $display("FAIL early_open wr=%b bank=%0d gnt=%b want 1 %0d %b",
                     write_rq, access_bank, gnt, b, oh(3));
        end
        mp = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            op_trigger = 1'b1;
            op_bank    = b;
            tick();
            checks++;
            if (beat !== oh(3)) begin
                errors++;
                $display("FAIL early_beat%0d got %b want %b", i, beat, oh(3));
            end
        end
        op_trigger = 1'b0;
        req[3] = 1'b0;
        lat = 0;
        stray = 0;
        for (int t = 1; t <= 4 && lat == 0; t++) begin
            tick();
            if (beat !== '0) stray = 1;
            if (stop_access) lat = t;
        end
        checks++;
        if (lat !== 1 || access_bank !== b || done !== oh(3) || gnt !== '0) begin
            errors++;
            $display("FAIL early_close lat=%0d bank=%0d done=%b gnt=%b want 1 %0d %b 0000",
                     lat, access_bank, done, gnt, b, oh(3));
        end
        settle(TRP + 2);
        checks++;
        if (stray || beat !== '0) begin
            errors++;
            $display("FAIL early_no_beat stray=%b beat=%b want 0", stray, beat);
        end
    endtask

    task automatic test_random(input int rounds);
        for (int rd = 0; rd < rounds; rd++) begin
            int          bk [4];
            int          own [4];
            int          cnt [4];
            bit          opn [4];
            logic [11:0] rows [NREQ];
            logic        wr [NREQ];
            logic [NREQ-1:0] sel;
            int          order [$];
            int          seen, last, n, closed, tmp;
            logic [NREQ-1:0] exp_beat;
            bit          stray;
            bk = '{0, 1, 2, 3};
            for (int i = 3; i > 0; i--) begin
                int j;
                j = $urandom_range(0, i);
                tmp = bk[i]; bk[i] = bk[j]; bk[j] = tmp;
            end
            sel = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int b = 0; b < 4; b++) begin
                opn[b] = 0; cnt[b] = 0; own[b] = 0;
            end
            for (int k = 0; k < NREQ; k++) begin
                rows[k] = 12'($urandom);
                wr[k]   = 1'($urandom);
                if (sel[k]) begin
                    set_req(k, wr[k], 2'(bk[k]), rows[k]);
                    own[bk[k]] = k;
                    opn[bk[k]] = 1;
                end
            end
            for (int off = 0; off < NREQ; off++) begin
                if (sel[(mp + off) % NREQ]) order.push_back((mp + off) % NREQ);
            end
            n = order.size();
            seen = 0;
            last = -1;
            for (int t = 0; t < 3 * NREQ + 4 && seen < n; t++) begin
                tick();
                if (read_rq || write_rq || stop_access) begin
                    int e;
                    e = order[seen];
                    checks++;
                    if (stop_access !== 1'b0 || write_rq !== wr[e] ||
                        access_bank !== 2'(bk[e]) || address_select !== rows[e] ||
                        (last >= 0 && cyc - last !== 2)) begin
                        errors++;
                        $display("FAIL rand%0d_open%0d wr=%b bank=%0d row=%h want req %0d bank %0d row %h",
                                 rd, seen, write_rq, access_bank, address_select,
                                 e, bk[e], rows[e]);
                    end
                    last = cyc;
                    seen++;
                end
            end
            checks++;
            if (seen !== n || gnt !== sel) begin
                errors++;
                $display("FAIL rand%0d_opens got %0d gnt=%b want %0d %b",
                         rd, seen, gnt, n, sel);
            end
            mp = (order[n - 1] + 1) % NREQ;
            closed = 0;
            stray = 0;
            for (int t = 0; t < 400 && closed < n; t++) begin
                int cand [$];
                for (int b = 0; b < 4; b++) begin
                    if (opn[b] && cnt[b] < BL) cand.push_back(b);
                end
                exp_beat = '0;
                op_trigger = 1'b0;
                if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                    int pk;
                    pk = cand[$urandom_range(0, cand.size() - 1)];
                    op_trigger = 1'b1;
                    op_bank    = 2'(pk);
                    exp_beat   = oh(own[pk]);
                    cnt[pk]++;
                end
                tick();
                checks++;
                if (beat !== exp_beat) begin
                    errors++;
                    $display("FAIL rand%0d_beat got %b want %b", rd, beat, exp_beat);
                end
                if (read_rq || write_rq) stray = 1;
                if (stop_access) begin
                    int ab;
                    ab = int'(access_bank);
                    checks++;
                    if (!opn[ab] || cnt[ab] != BL || done !== oh(own[ab])) begin
                        errors++;
                        $display("FAIL rand%0d_close bank=%0d done=%b want full bank, done %b",
                                 rd, ab, done, oh(own[ab]));
                    end
                    opn[ab] = 0;
                    req[own[ab]] = 1'b0;
                    closed++;
                end
            end
            op_trigger = 1'b0;
            checks++;
            if (closed !== n || stray) begin
                errors++;
                $display("FAIL rand%0d_done closes=%0d stray_open=%b want %0d 0",
                         rd, closed, stray, n);
            end
            req = '0;
            settle(TRP + 2);
        end
    endtask

    task automatic test_spurious();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clean got %b want 0", err);
        end
        op_trigger = 1'b1;
        op_bank    = 2'd3;
        tick();
        op_trigger = 1'b0;
        checks++;
        if (err !== 1'b1 || beat !== '0) begin
            errors++;
            $display("FAIL spurious err=%b beat=%b want 1 0000", err, beat);
        end
        settle(3);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b want 1", err);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] r1, r3;
        set_req(0, 1'b0, 2'd0, 12'($urandom));
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            op_trigger = 1'b1;
            op_bank    = 2'd0;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 34'd0) begin
            errors++;
            $display("FAIL reset_mid got %h want 0", outs());
        end
        req = '0;
        op_trigger = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        mp = 0;
        r1 = 12'($urandom);
        r3 = 12'($urandom);
        set_req(3, 1'b1, 2'd2, r3);
        set_req(1, 1'b0, 2'd1, r1);
        tick();
        checks++;
        if (read_rq !== 1'b1 || access_bank !== 2'd1 ||
            address_select !== r1 || gnt !== oh(1)) begin
            errors++;
            $display("FAIL post_reset_open rd=%b bank=%0d row=%h gnt=%b want 1 1 %h %b",
                     read_rq, access_bank, address_select, gnt, r1, oh(1));
        end
        tick();
        tick();
        checks++;
        if (write_rq !== 1'b1 || access_bank !== 2'd2 ||
            gnt !== (oh(1) | oh(3))) begin
            errors++;
            $display("FAIL post_reset_second wr=%b bank=%0d gnt=%b want 1 2 %b",
                     write_rq, access_bank, gnt, oh(1) | oh(3));
        end
        req = '0;
        settle(TRP + 8);
        checks++;
        if (gnt !== '0) begin
            errors++;
            $display("FAIL post_reset_release gnt=%b want 0", gnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d want finish", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_bank_conflict();
        test_early_release();
        test_random(6);
        test_spurious();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
